// File: rtl/isqrt_iter_responder.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_iter_responder
//  Description : Shared integer square-root responder. Accepts x_vld/x
//                requests, returns y = floor(sqrt(x)) with a one-cycle
//                y_vld strobe. Uses a digit-by-digit datapath that consumes
//                2 radicand bits per cycle. Requests arriving while busy wait
//                in a small in-order FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter_responder #(
    parameter int N_BITS     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  x_vld,
    input  logic [N_BITS-1:0]     x,
    output logic                  y_vld,
    output logic [N_BITS/2-1:0]   y,
    output logic                  busy,
    output logic                  overflow
);

    localparam int c_ROOT_W = N_BITS / 2;
    localparam int c_REM_W  = c_ROOT_W + 2;
    localparam int c_CNT_W  = (c_ROOT_W > 1) ? $clog2(c_ROOT_W) : 1;
    localparam int c_AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(c_ROOT_W - 1);
    // Pointer XOR pattern meaning "same slot, different lap" (FIFO full).
    localparam logic [c_PTR_W-1:0] c_FULL_XOR  = c_PTR_W'(1) << (c_PTR_W - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [N_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_AW-1:0]     w_wr_idx;
    logic [c_AW-1:0]     w_rd_idx;
    logic [c_PTR_W-1:0]  w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;

    logic [N_BITS-1:0]   r_op;
    logic [c_REM_W-1:0]  r_rem;
    logic [c_ROOT_W-1:0] r_root;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_ROOT_W-1:0] r_y;
    logic                r_y_vld;
    logic                r_busy;
    logic                r_overflow;

    // ------------------------------------------------------------------
    // Request steering
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_slot;
    logic w_pop;
    logic w_bypass;
    logic w_start;
    logic w_push_req;
    logic w_push;
    logic w_drop;
    logic w_last;
    logic [N_BITS-1:0] w_start_x;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = ((r_wr_ptr ^ r_rd_ptr) == c_FULL_XOR);
    // A new job may start in IDLE or in the DONE cycle; queued work first.
    assign w_slot     = (r_state == c_IDLE) || (r_state == c_DONE);
    assign w_pop      = w_slot && !w_empty;
    assign w_bypass   = w_slot && w_empty && x_vld;
    assign w_start    = w_pop || w_bypass;
    assign w_push_req = x_vld && !w_bypass;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_start_x  = w_pop ? r_mem[w_rd_idx] : x;
    assign w_last     = (r_cnt == c_LAST_ITER);

    assign w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);

    generate
        if (FIFO_DEPTH > 1) begin : g_idx_multi
            assign w_wr_idx = r_wr_ptr[c_AW-1:0];
            assign w_rd_idx = r_rd_ptr[c_AW-1:0];
        end else begin : g_idx_single
            assign w_wr_idx = '0;
            assign w_rd_idx = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // One root digit per cycle
    // ------------------------------------------------------------------
    logic [1:0]          w_op_top;
    logic [c_REM_W-1:0]  w_rem_lo;
    logic [c_REM_W-1:0]  w_trial;
    logic                w_rem_ge;
    logic [c_REM_W-1:0]  w_rem_nxt;
    logic [c_ROOT_W-1:0] w_root_nxt;

    assign w_op_top = r_op[N_BITS-1 -: 2];
    assign w_rem_lo = {r_rem[c_REM_W-3:0], w_op_top};
    assign w_trial  = {r_root, 2'b01};
    // The shifted remainder is conceptually c_REM_W+2 bits wide; any set bit
    // above w_rem_lo makes it exceed the trial. The difference always fits
    // back into c_REM_W bits, so the low-order subtraction is exact.
    assign w_rem_ge   = (r_rem[c_REM_W-1 -: 2] != 2'b00) || (w_rem_lo >= w_trial);
    assign w_rem_nxt  = w_rem_ge ? (w_rem_lo - w_trial) : w_rem_lo;
    assign w_root_nxt = {r_root[c_ROOT_W-2:0], w_rem_ge};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = c_IDLE;
        case (r_state)
            c_IDLE:  w_state_nxt = w_start ? c_CALC : c_IDLE;
            c_CALC:  w_state_nxt = w_last  ? c_DONE : c_CALC;
            c_DONE:  w_state_nxt = w_start ? c_CALC : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output decode, registered below so no output can glitch
    logic w_y_vld_nxt;
    logic w_busy_nxt;
    logic w_overflow_nxt;

    always_comb begin
        w_y_vld_nxt    = (w_state_nxt == c_DONE);
        w_busy_nxt     = (w_state_nxt != c_IDLE) || (w_wr_ptr_nxt != w_rd_ptr_nxt);
        w_overflow_nxt = w_drop;
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y_vld    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_y_vld    <= w_y_vld_nxt;
            r_busy     <= w_busy_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Pending-request storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_idx] <= x;
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Datapath: load a new job or run one iteration, capture root at the end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op   <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_y    <= '0;
        end else if (w_start) begin
            r_op   <= w_start_x;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (r_state == c_CALC) begin
            r_op   <= {r_op[N_BITS-3:0], 2'b00};
            r_rem  <= w_rem_nxt;
            r_root <= w_root_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_y <= w_root_nxt;
            end
        end
    end

    assign y_vld    = r_y_vld;
    assign y        = r_y;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_iter_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_iter_responder
//  Description : Self-checking bench for isqrt_iter_responder. A job-level
//                reference model predicts every output each cycle; directed
//                sequences additionally pin hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_iter_responder;

    localparam int N_BITS     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam int LAT        = N_BITS / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_vld = 1'b0;
    logic [31:0] x = '0;
    logic        y_vld;
    logic [15:0] y;
    logic        busy;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    isqrt_iter_responder #(
        .N_BITS     (N_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x_vld    (x_vld),
        .x        (x),
        .y_vld    (y_vld),
        .y        (y),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference root: largest r with r*r <= v
    function automatic logic [15:0] isqrt(input logic [31:0] v);
        longint lo;
        longint hi;
        longint mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'({32'd0, v})) lo = mid;
            else hi = mid - 1;
        end
        return 16'(lo);
    endfunction

    // ------------------------------------------------------------------
    // Job-level model: one server with a fixed compute time and a bounded
    // queue; jobs start on the cycle the server is free, queue first.
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    bit          m_active = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_job    = '0;
    logic        m_yv     = 1'b0;
    logic        m_ovf    = 1'b0;
    logic        m_busy   = 1'b0;
    logic [15:0] m_y      = '0;

    always @(posedge clk or negedge rst) begin : model
        bit          slot;
        bit          start;
        logic [31:0] nx;
        if (!rst) begin
            m_q.delete();
            m_active <= 1'b0;
            m_left   <= 0;
            m_yv     <= 1'b0;
            m_ovf    <= 1'b0;
            m_busy   <= 1'b0;
            m_y      <= '0;
        end else begin
            slot  = !m_active || (m_left == 0);
            start = 1'b0;
            nx    = '0;
            m_ovf <= 1'b0;
            m_yv  <= 1'b0;
            if (slot) begin
                if (m_q.size() != 0) begin
                    nx = m_q.pop_front();
                    start = 1'b1;
                    if (x_vld) m_q.push_back(x);
                end else if (x_vld) begin
                    nx = x;
                    start = 1'b1;
                end
            end else if (x_vld) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(x);
                else m_ovf <= 1'b1;
            end
            if (start) begin
                m_active <= 1'b1;
                m_job    <= nx;
                m_left   <= LAT;
            end else if (slot) begin
                m_active <= 1'b0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_yv <= 1'b1;
                    m_y  <= isqrt(m_job);
                end
            end
            m_busy <= start || !slot || (m_q.size() != 0);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("y_vld",    {31'd0, y_vld},    {31'd0, m_yv});
        chk("y",        {16'd0, y},        {16'd0, m_y});
        chk("busy",     {31'd0, busy},     {31'd0, m_busy});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end

    // ------------------------------------------------------------------
    // Directed helpers (all called at a falling edge)
    // ------------------------------------------------------------------
    int          got_t [4];
    logic [15:0] got_y [4];
    int          got_n;
    int          ovf_seen;

    task automatic issue(input logic [31:0] v);
        x_vld = 1'b1;
        x     = v;
        @(negedge clk);
        x_vld = 1'b0;
        x     = $urandom;
    endtask

    task automatic wait_y(output int cyc);
        cyc = 0;
        while (!y_vld && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (!y_vld) chk("wait_y_timeout", 32'd0, 32'd1);
    endtask

    task automatic collect(input int n, input int budget);
        int c;
        c        = 0;
        got_n    = 0;
        ovf_seen = 0;
        while (got_n < n && c < budget) begin
            @(negedge clk);
            c++;
            if (overflow) ovf_seen++;
            if (y_vld) begin
                got_t[got_n] = c;
                got_y[got_n] = y;
                got_n++;
            end
        end
        if (got_n < n) chk("collect_timeout", got_n, n);
    endtask

    logic [31:0] dir_x [4] = '{32'd0, 32'd1, 32'd15, 32'd16};
    logic [15:0] dir_y [4] = '{16'd0, 16'd1, 16'd3, 16'd4};
    logic [31:0] bnd_x [3] = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
    logic [15:0] bnd_y [3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};

    initial begin : stim
        int          cyc;
        logic [31:0] k;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_y_vld", {31'd0, y_vld}, 32'd0);
        chk("reset_y",     {16'd0, y},     32'd0);
        chk("reset_busy",  {31'd0, busy},  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Small values from IDLE, with gaps
        for (int i = 0; i < 4; i++) begin
            issue(dir_x[i]);
            wait_y(cyc);
            chk("small_latency", cyc, LAT);
            chk("small_y", {16'd0, y}, {16'd0, dir_y[i]});
            @(negedge clk);
            chk("small_pulse_width", {31'd0, y_vld}, 32'd0);
            repeat (3) @(negedge clk);
        end

        // Remainder-width boundary
        for (int i = 0; i < 3; i++) begin
            issue(bnd_x[i]);
            wait_y(cyc);
            chk("bound_latency", cyc, LAT);
            chk("bound_y", {16'd0, y}, {16'd0, bnd_y[i]});
            repeat (3) @(negedge clk);
        end

        // Three back-to-back requests, all served in order
        x_vld = 1'b1; x = 32'd9;     @(negedge clk);
        x = 32'd100;                 @(negedge clk);
        x = 32'd65536;               @(negedge clk);
        x_vld = 1'b0;
        collect(3, 120);
        chk("b2b_first_time", got_t[0], LAT - 2);
        chk("b2b_y0", {16'd0, got_y[0]}, 32'd3);
        chk("b2b_y1", {16'd0, got_y[1]}, 32'd10);
        chk("b2b_y2", {16'd0, got_y[2]}, 32'd256);
        chk("b2b_gap01", got_t[1] - got_t[0], LAT + 1);
        chk("b2b_gap12", got_t[2] - got_t[1], LAT + 1);
        chk("b2b_no_ovf", ovf_seen, 0);
        chk("b2b_busy_at_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("b2b_busy_fall", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        // Four back-to-back: the fourth overflows the queue
        x_vld = 1'b1; x = 32'd4;     @(negedge clk);
        x = 32'd25;                  @(negedge clk);
        x = 32'd49;                  @(negedge clk);
        x = 32'd81;                  @(negedge clk);
        x_vld = 1'b0;
        chk("drop_ovf_pulse", {31'd0, overflow}, 32'd1);
        collect(3, 120);
        chk("drop_y0", {16'd0, got_y[0]}, 32'd2);
        chk("drop_y1", {16'd0, got_y[1]}, 32'd5);
        chk("drop_y2", {16'd0, got_y[2]}, 32'd7);
        chk("drop_gap", got_t[2] - got_t[1], LAT + 1);
        chk("drop_ovf_once", ovf_seen, 0);
        repeat (LAT + 4) @(negedge clk);
        chk("drop_idle_busy", {31'd0, busy}, 32'd0);

        // Abort mid-calculation
        issue(32'd1000000);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_y_vld", {31'd0, y_vld}, 32'd0);
        chk("abort_y",     {16'd0, y},     32'd0);
        @(negedge clk);
        chk("abort_busy",  {31'd0, busy},  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        issue(32'd144);
        wait_y(cyc);
        chk("abort_new_latency", cyc, LAT);
        chk("abort_new_y", {16'd0, y}, 32'd12);
        repeat (3) @(negedge clk);

        // Bypass in the DONE cycle
        issue(32'd49);
        wait_y(cyc);
        chk("bypass_first_y", {16'd0, y}, 32'd7);
        x_vld = 1'b1;
        x     = 32'd121;
        @(negedge clk);
        x_vld = 1'b0;
        cyc = 1;
        while (!y_vld && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk("bypass_period", cyc, LAT + 1);
        chk("bypass_second_y", {16'd0, y}, 32'd11);
        repeat (3) @(negedge clk);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            x_vld = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: x = $urandom;
                1: x = $urandom_range(0, 255);
                2: x = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: begin
                    k = $urandom_range(0, 65535);
                    x = k * k - $urandom_range(0, 1);
                end
            endcase
            if ($urandom_range(0, 199) == 0) rst = 1'b0;
            else rst = 1'b1;
            @(negedge clk);
        end
        x_vld = 1'b0;
        rst   = 1'b1;
        repeat (3 * (LAT + 1) + 5) @(negedge clk);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
